// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU and flag-mode encodings, P bit positions,
// and the stored-flag record used by the status register.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_PASS = 4'd0,
        ALU_ADC  = 4'd1,
        ALU_SBC  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_ORA  = 4'd4,
        ALU_EOR  = 4'd5,
        ALU_ASL  = 4'd6,
        ALU_LSR  = 4'd7,
        ALU_ROL  = 4'd8,
        ALU_ROR  = 4'd9,
        ALU_INC  = 4'd10,
        ALU_DEC  = 4'd11,
        ALU_CMP  = 4'd12
    } alu_mode_t;

    // Codes 14 and 15 are reserved and treated as FM_NONE.
    typedef enum logic [3:0] {
        FM_NONE = 4'd0,
        FM_NZ   = 4'd1,
        FM_NZC  = 4'd2,
        FM_NZCV = 4'd3,
        FM_BIT  = 4'd4,
        FM_SEC  = 4'd5,
        FM_CLC  = 4'd6,
        FM_SEI  = 4'd7,
        FM_CLI  = 4'd8,
        FM_CLV  = 4'd9,
        FM_SED  = 4'd10,
        FM_CLD  = 4'd11,
        FM_PLP  = 4'd12,
        FM_RTI  = 4'd13
    } flag_mode_t;

    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } flags_t;

    // Assemble a P byte; bit 5 always reads 1, bit 4 is supplied by the caller.
    function automatic logic [7:0] p_byte(input flags_t f, input logic b);
        return {f.n, f.v, 1'b1, b, f.d, f.i, f.z, f.c};
    endfunction

endpackage

// File: rtl/status_register_if.sv
// Signal bundle between the decoder/ALU/sequencer side (master) and the
// status register (slave).
interface status_register_if;
    logic [3:0] flag_mode;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;
    logic [7:0] data_in;
    logic       sync;
    logic       irq_take;
    logic       push_brk;
    logic [7:0] p_out;
    logic [7:0] p_push;
    logic       carry;
    logic       irq_inhibit;

    modport master (
        output flag_mode, alu_result, alu_carry, alu_overflow, data_in,
               sync, irq_take, push_brk,
        input  p_out, p_push, carry, irq_inhibit
    );

    modport slave (
        input  flag_mode, alu_result, alu_carry, alu_overflow, data_in,
               sync, irq_take, push_brk,
        output p_out, p_push, carry, irq_inhibit
    );
endinterface

// File: rtl/status_register_flag_next.sv
// Combinational next-flag function: applies one flag_mode operation to the
// current flags. Interrupt-entry overrides are applied by the caller.
module flag_next
    import cpu_pkg::*;
(
    input  logic [3:0] flag_mode,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  flags_t     mem_flags,
    input  flags_t     flags_cur,
    output flags_t     flags_new
);

    logic result_zero;

    assign result_zero = (alu_result == 8'h00);

    always_comb begin
        flags_new = flags_cur;
        case (flag_mode_t'(flag_mode))
            FM_NZ: begin
                flags_new.n = alu_result[7];
                flags_new.z = result_zero;
            end
            FM_NZC: begin
                flags_new.n = alu_result[7];
                flags_new.z = result_zero;
                flags_new.c = alu_carry;
            end
            FM_NZCV: begin
                flags_new.n = alu_result[7];
                flags_new.z = result_zero;
                flags_new.c = alu_carry;
                flags_new.v = alu_overflow;
            end
            // BIT takes N/V from memory but Z from the A AND M result.
            FM_BIT: begin
                flags_new.n = mem_flags.n;
                flags_new.v = mem_flags.v;
                flags_new.z = result_zero;
            end
            FM_SEC:         flags_new.c = 1'b1;
            FM_CLC:         flags_new.c = 1'b0;
            FM_SEI:         flags_new.i = 1'b1;
            FM_CLI:         flags_new.i = 1'b0;
            FM_CLV:         flags_new.v = 1'b0;
            FM_SED:         flags_new.d = 1'b1;
            FM_CLD:         flags_new.d = 1'b0;
            FM_PLP, FM_RTI: flags_new = mem_flags;
            default:        flags_new = flags_cur;
        endcase
    end

endmodule

// File: rtl/status_register.sv
// 6502 processor status register: flag storage, interrupt-mask timing and
// assembly of the P byte for reads and stack pushes.
module status_register
    import cpu_pkg::*;
#(
    parameter bit RESET_I = 1'b1,
    parameter bit RESET_D = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    status_register_if.slave   bus
);

    flags_t flags_reg;
    flags_t flags_next;
    flags_t mode_flags;
    flags_t mem_flags;
    logic   irq_inhibit_reg;
    logic   irq_inhibit_next;

    assign mem_flags = '{n: bus.data_in[P_N], v: bus.data_in[P_V],
                         d: bus.data_in[P_D], i: bus.data_in[P_I],
                         z: bus.data_in[P_Z], c: bus.data_in[P_C]};

    flag_next u_flag_next (
        .flag_mode    (bus.flag_mode),
        .alu_result   (bus.alu_result),
        .alu_carry    (bus.alu_carry),
        .alu_overflow (bus.alu_overflow),
        .mem_flags    (mem_flags),
        .flags_cur    (flags_reg),
        .flags_new    (mode_flags)
    );

    // The inhibit lags I by one instruction except on RTI, which loads it
    // directly; interrupt entry masks immediately to block re-entry.
    always_comb begin
        flags_next       = mode_flags;
        irq_inhibit_next = irq_inhibit_reg;
        if (bus.irq_take) begin
            flags_next.i = 1'b1;
        end
        if (bus.irq_take) begin
            irq_inhibit_next = 1'b1;
        end else if (bus.flag_mode == FM_RTI) begin
            irq_inhibit_next = bus.data_in[P_I];
        end else if (bus.sync) begin
            irq_inhibit_next = flags_reg.i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_reg       <= '{n: 1'b0, v: 1'b0, d: RESET_D, i: RESET_I,
                                 z: 1'b0, c: 1'b0};
            irq_inhibit_reg <= RESET_I;
        end else begin
            flags_reg       <= flags_next;
            irq_inhibit_reg <= irq_inhibit_next;
        end
    end

    assign bus.p_out       = p_byte(flags_reg, 1'b1);
    assign bus.p_push      = p_byte(flags_reg, bus.push_brk);
    assign bus.carry       = flags_reg.c;
    assign bus.irq_inhibit = irq_inhibit_reg;

endmodule

// File: doc/status_register.md
Name: status_register

Overview:
- 6502 processor status register (P), sitting directly downstream of the ALU.
- Captures the ALU's 8-bit result, carry_out and overflow, and updates N/V/Z/C according to the flag mode the decoder supplies for the current instruction.
- Also executes the flag instructions (SEC/CLC/SEI/CLI/CLV/SED/CLD), BIT, PLP/RTI loads and the interrupt-entry I set.
- Supplies carry_in back to the ALU, the byte pushed by PHP/BRK, and a one-instruction-delayed IRQ inhibit for the interrupt sequencer.

Parameters:
- RESET_I, 1, value of the I flag and irq_inhibit after reset.
- RESET_D, 0, value of the D flag after reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flag_mode  input  4  flag operation for this cycle (flag_mode_t).
- alu_result  input  8  ALU result byte (alu_out).
- alu_carry  input  1  ALU carry_out.
- alu_overflow  input  1  ALU overflow.
- data_in  input  8  memory/bus byte, used for BIT, PLP and RTI.
- sync  input  1  instruction-boundary strobe: high in the opcode-fetch cycle.
- irq_take  input  1  interrupt entry: set I this cycle.
- push_brk  input  1  B bit value for p_push (1 = PHP/BRK, 0 = IRQ/NMI).
- p_out  output  8  current P as {N,V,1,1,D,I,Z,C}.
- p_push  output  8  {N,V,1,push_brk,D,I,Z,C}.
- carry  output  1  C flag, feeds the ALU carry_in.
- irq_inhibit  output  1  interrupt mask used by the interrupt sequencer.

Behaviour:
- Storage: registered bits N, V, D, I, Z, C and irq_inhibit. Bits 5 and 4 are not stored; p_out[5] and p_out[4] read as 1.
- Reset (synchronous, clk edge with reset=1):
  - N=V=Z=C=0, D=RESET_D, I=RESET_I, irq_inhibit=RESET_I.
  - p_out=8'h34 at default parameters.
  - reset overrides all other inputs, including in the middle of an instruction.
- All flag outputs are registered and take effect on the edge after the cycle in which flag_mode is presented.
- p_push and carry are combinational functions of the stored bits (zero extra latency).
- Z is computed as (byte == 8'h00) and N as byte[7], with byte being the source given per mode below.
- Flag modes; flags not listed are held:
  - FM_NONE: hold all flags.
  - FM_NZ: N, Z from alu_result.
  - FM_NZC: N, Z from alu_result; C=alu_carry. Used for CMP/CPX/CPY, shifts and rotates.
  - FM_NZCV: N, Z from alu_result; C=alu_carry; V=alu_overflow. Used for ADC/SBC.
  - FM_BIT: N=data_in[7], V=data_in[6], Z=(alu_result==0), where alu_result is the A AND M result.
  - FM_SEC / FM_CLC: C=1 / C=0.
  - FM_SEI / FM_CLI: I=1 / I=0.
  - FM_CLV: V=0.
  - FM_SED / FM_CLD: D=1 / D=0.
  - FM_PLP: N, V, D, I, Z, C loaded from data_in bits 7, 6, 3, 2, 1, 0; data_in[5:4] are ignored.
  - FM_RTI: same load as FM_PLP, and irq_inhibit is loaded with data_in[2] on the same edge.
  - Codes 14–15 are reserved and behave as FM_NONE.
- irq_inhibit delay:
  - On a sync=1 cycle that is not FM_RTI, irq_inhibit takes the I value stored before that edge.
  - Result: CLI, SEI and PLP change the interrupt mask one instruction late; RTI changes it immediately.
- irq_take:
  - Sets I=1 on that edge.
  - When flag_mode is also active, the mode update is applied first and irq_take then forces I=1; the other flags from the mode still update.
  - irq_take also forces irq_inhibit=1 on the same edge, so no back-to-back interrupt entry is possible.
- Simultaneous sync and flag_mode in the same cycle: both actions occur. irq_inhibit samples the old I; the flags take their new values.
- No flag is written from alu_result in FM_NONE, regardless of the ALU's default pass-through output.

Decomposition:
- Shared package cpu_pkg:
  - flag_mode_t: 4-bit enum in the order listed under Behaviour, FM_NONE = 0.
  - Flag bit-position constants P_C=0, P_Z=1, P_I=2, P_D=3, P_B=4, P_U=5, P_V=6, P_N=7.
  - The ALU mode enum already used by the ALU moves into the same package.
- One combinational sub-module, flag_next: maps (flag_mode, alu inputs, data_in, current flags) to next flags.
- status_register holds the registers, the irq_inhibit timing and the output assembly.

Test Plan:
- Reset: hold reset 2 cycles with alu_result=8'hFF and flag_mode=FM_NZCV -> p_out=8'h34, irq_inhibit=1, carry=0.
- ADC-style update: FM_NZCV, alu_result=8'h80, alu_carry=0, alu_overflow=1 -> next cycle p_out=8'hF4. Then FM_NZC, alu_result=8'h00, alu_carry=1 -> p_out=8'h77 (V held).
- BIT: FM_BIT, data_in=8'hC0, alu_result=8'h00 -> N=1, V=1, Z=1, C unchanged.
- CLI delay: I=1; FM_CLI with sync=0 -> I=0 next cycle. At the next sync, irq_inhibit is still 1; at the following sync, irq_inhibit=0.
- RTI versus PLP: FM_PLP with data_in=8'h00 and sync=1 -> I=0 and irq_inhibit=1. Then FM_RTI with data_in=8'h04 -> I=1 and irq_inhibit=1 on the same edge; then FM_RTI with data_in=8'h00 -> irq_inhibit=0 immediately.
- Interrupt entry and push: irq_take=1 together with FM_CLI -> I=1 and irq_inhibit=1. With N=Z=C=1 and push_brk=0 -> p_push=8'hA7; with push_brk=1 -> p_push=8'hB7.
